// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between the TX byte source (master) and uart_tx_ctrl (slave).
// Latency: none, wires only.
// Backpressure: the byte source holds valid and data until it sees ready high.
interface uart_tx_ctrl_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;

   modport master (output data, output valid, input  ready);
   modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sends start bit, data LSB first, optional even parity
// (build macro UART_TX_PARITY_EN), then stop bits. TXD falls one cycle after accept.
// Backpressure: ready is low for the whole frame; valid seen while busy is ignored.
module uart_tx_ctrl #(
   parameter int CLK_DIV   = 16,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic            clk,
   input  logic            r,
   uart_tx_ctrl_if.slave   src,
   output logic            txd,
   output logic            busy,
   output logic            bit_ce
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int CW = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
`ifdef UART_TX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t                state, state_nxt;
   logic [DW-1:0]         div, div_nxt;
   logic [CW-1:0]         cnt, cnt_nxt, cnt_max;
   logic [DATA_BITS-1:0]  shreg, shreg_nxt;
   logic                  tick;
   logic                  txd_nxt, busy_nxt, bit_ce_nxt;
`ifdef UART_TX_PARITY_EN
   logic                  par, par_nxt;
`endif

   // Last cycle of the current serial bit; divider sits at 0 in idle so this never fires there.
   assign tick = (div == DW'(CLK_DIV - 1));

   // The source may hand over a byte only while the state register says idle.
   assign src.ready = (state == S_IDLE);

   // State register plus divider, bit counter and shift register.
   always_ff @(posedge clk) begin
      if (r) begin
         state <= S_IDLE;
         div   <= '0;
         cnt   <= '0;
         shreg <= '0;
`ifdef UART_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         div   <= div_nxt;
         cnt   <= cnt_nxt;
         shreg <= shreg_nxt;
`ifdef UART_TX_PARITY_EN
         par   <= par_nxt;
`endif
      end
   end

   // Next-state: each non-idle state lasts whole bit periods and advances on tick.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (src.valid) state_nxt = S_START;
         S_START:  if (tick) state_nxt = S_DATA;
         S_DATA:
            if (tick && cnt == CW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
               state_nxt = S_PARITY;
`else
               state_nxt = S_STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
         S_PARITY: if (tick) state_nxt = S_STOP;
`endif
         S_STOP:   if (tick && cnt == CW'(STOP_BITS - 1)) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Datapath next values: divider wrap, counter clear on state change, byte capture and shift.
   always_comb begin
      div_nxt   = (state == S_IDLE || tick) ? '0 : div + DW'(1);
      cnt_max   = (state == S_DATA) ? CW'(DATA_BITS - 1) : CW'(STOP_BITS - 1);
      cnt_nxt   = cnt;
      shreg_nxt = shreg;
`ifdef UART_TX_PARITY_EN
      par_nxt   = par;
`endif
      if (state_nxt != state)
         cnt_nxt = '0;
      else if (tick && cnt != cnt_max)
         cnt_nxt = cnt + CW'(1);
      if (state == S_IDLE && src.valid) begin
         shreg_nxt = src.data;
`ifdef UART_TX_PARITY_EN
         par_nxt   = ^src.data;
`endif
      end else if (state == S_DATA && tick) begin
         shreg_nxt = shreg >> 1;
      end
   end

   // Outputs are computed from next-state values so the registered copies line up with the state.
   always_comb begin
      txd_nxt = 1'b1;
      case (state_nxt)
         S_START:  txd_nxt = 1'b0;
         S_DATA:   txd_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: txd_nxt = par_nxt;
`endif
         default:  txd_nxt = 1'b1;
      endcase
      busy_nxt   = (state_nxt != S_IDLE);
      bit_ce_nxt = busy_nxt && (div_nxt == DW'(CLK_DIV - 1));
   end

   // Output registers; reset forces the line idle high with no partial stop bit.
   always_ff @(posedge clk) begin
      if (r) begin
         txd    <= 1'b1;
         busy   <= 1'b0;
         bit_ce <= 1'b0;
      end else begin
         txd    <= txd_nxt;
         busy   <= busy_nxt;
         bit_ce <= bit_ce_nxt;
      end
   end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (4/8/1 and 2/5/2) checked bit by bit against a frame model.
// Expected bytes are queued when driven and popped when the monitor sees the accept.
// Parity frames are modelled when UART_TX_PARITY_EN is defined.
module tb_uart_tx_ctrl;
   localparam int CD_A = 4, DB_A = 8, SB_A = 1;
   localparam int CD_B = 2, DB_B = 5, SB_B = 2;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int F_A = CD_A * (1 + DB_A + PAR + SB_A);
   localparam int F_B = CD_B * (1 + DB_B + PAR + SB_B);

   logic clk = 1'b0;
   logic r   = 1'b1;
   logic txd_a, busy_a, bce_a, txd_b, busy_b, bce_b;
   int   n_chk = 0, n_err = 0, cyc = 0;
   int   acc_cyc [2];
   int   t_first;
   logic [7:0] sb_a [$];
   logic [7:0] sb_b [$];
   logic [4:0] obs [2];   // {valid, ready, txd, busy, bit_ce}

   uart_tx_ctrl_if #(.DATA_BITS(DB_A)) ia ();
   uart_tx_ctrl_if #(.DATA_BITS(DB_B)) ib ();

   uart_tx_ctrl #(.CLK_DIV(CD_A), .DATA_BITS(DB_A), .STOP_BITS(SB_A)) dut_a (
      .clk(clk), .r(r), .src(ia), .txd(txd_a), .busy(busy_a), .bit_ce(bce_a));
   uart_tx_ctrl #(.CLK_DIV(CD_B), .DATA_BITS(DB_B), .STOP_BITS(SB_B)) dut_b (
      .clk(clk), .r(r), .src(ib), .txd(txd_b), .busy(busy_b), .bit_ce(bce_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign obs[0] = {ia.valid, ia.ready, txd_a, busy_a, bce_a};
   assign obs[1] = {ib.valid, ib.ready, txd_b, busy_b, bce_b};

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic chk_idle(input int id, input string tag);
      string p = (id == 0) ? "a_" : "b_";
      chk_eq({p, tag, "_txd"},   32'(obs[id][2]), 32'd1);
      chk_eq({p, tag, "_ready"}, 32'(obs[id][3]), 32'd1);
      chk_eq({p, tag, "_busy"},  32'(obs[id][1]), 32'd0);
      chk_eq({p, tag, "_bitce"}, 32'(obs[id][0]), 32'd0);
   endtask

   // Frame model and scoreboard consumer for one instance.
   task automatic monitor(input int id);
      int cd = (id == 0) ? CD_A : CD_B;
      int db = (id == 0) ? DB_A : DB_B;
      int sb = (id == 0) ? SB_A : SB_B;
      int nb, pulses;
      string p = (id == 0) ? "a_" : "b_";
      logic [15:0] bits;
      logic [7:0]  d;
      logic        pb;
      bit          done = 1'b0, abort;
      forever begin
         @(negedge clk);
         if (done) begin
            chk_idle(id, "post_frame");
            done = 1'b0;
         end
         if (obs[id][4] && obs[id][3] && !r) begin
            acc_cyc[id] = cyc;
            d = 8'h00;
            if (id == 0 && sb_a.size() > 0) d = sb_a.pop_front();
            else if (id == 1 && sb_b.size() > 0) d = sb_b.pop_front();
            else chk_eq({p, "sb_underflow"}, 32'((id == 0) ? sb_a.size() : sb_b.size()), 32'd1);
            bits = '1;
            bits[0] = 1'b0;
            pb = 1'b0;
            for (int i = 0; i < db; i++) begin
               bits[1 + i] = d[i];
               pb ^= d[i];
            end
            if (PAR == 1) bits[1 + db] = pb;
            nb = 1 + db + PAR + sb;
            abort = 1'b0;
            pulses = 0;
            for (int k = 0; k < nb && !abort; k++) begin
               for (int c = 0; c < cd && !abort; c++) begin
                  @(negedge clk);
                  chk_eq({p, "txd"},   32'(obs[id][2]), 32'(bits[k]));
                  chk_eq({p, "bitce"}, 32'(obs[id][0]), (c == cd - 1) ? 32'd1 : 32'd0);
                  chk_eq({p, "busy"},  32'(obs[id][1]), 32'd1);
                  chk_eq({p, "ready"}, 32'(obs[id][3]), 32'd0);
                  if (obs[id][0]) pulses++;
                  if (r) abort = 1'b1;
               end
            end
            if (!abort) begin
               chk_eq({p, "bitce_pulses"}, 32'(pulses), 32'(nb));
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present a byte and wait (bounded) for the accept edge; valid stays high on return.
   task automatic send(input int id, input logic [7:0] d);
      bit got = 1'b0;
      if (id == 0) begin
         ia.data = d; ia.valid = 1'b1; sb_a.push_back(d);
      end else begin
         ib.data = d[DB_B-1:0]; ib.valid = 1'b1; sb_b.push_back(d & 8'h1F);
      end
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (obs[id][3]) got = 1'b1;
      end
      step(1);
      chk_eq((id == 0) ? "a_accept" : "b_accept", 32'(got), 32'd1);
   endtask

   task automatic drop(input int id);
      if (id == 0) ia.valid = 1'b0;
      else ib.valid = 1'b0;
   endtask

   initial monitor(0);
   initial monitor(1);

   initial begin
      ia.valid = 1'b0; ia.data = '0;
      ib.valid = 1'b0; ib.data = '0;
      r = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_idle(0, "rst"); chk_idle(1, "rst");
      end
      step(0);
      @(posedge clk); #1 r = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_idle(0, "idle"); chk_idle(1, "idle");
      end
      step(1);

      // single frame
      send(0, 8'hA5); drop(0); step(F_A + 4);

      // parity pair (plain frames when parity is not built in)
      send(0, 8'h07); drop(0); step(F_A + 4);
      send(0, 8'h03); drop(0); step(F_A + 4);

      // back-to-back with valid held and data disturbed mid-frame
      send(0, 8'h55);
      t_first = acc_cyc[0];
      ia.data = 8'hFF;
      step(20);
      send(0, 8'hAA);
      chk_eq("a_b2b_gap", 32'(acc_cyc[0] - t_first), 32'(F_A + 1));
      drop(0); step(F_A + 4);

      // reset during the third data bit
      send(0, 8'h3C); drop(0);
      step(12);
      r = 1'b1;
      step(1);
      r = 1'b0;
      @(negedge clk);
      chk_idle(0, "mid_rst");
      step(2);
      send(0, 8'h81); drop(0); step(F_A + 4);

      // short data, two stop bits, fastest divider
      send(1, 8'h1F); drop(1); step(F_B + 4);

      chk_eq("a_sb_left", 32'(sb_a.size()), 32'd0);
      chk_eq("b_sb_left", 32'(sb_b.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sequences one serial frame per accepted byte: start bit, data bits LSB first, optional even parity, stop bits. It owns the baud-rate divider and the bit counter that step the transmit datapath, and exposes a valid/ready handshake to the byte source. It sits between the TX byte source and the TXD pad.

## Interface
- CLK_DIV, 16: clock cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- STOP_BITS, 1: stop bits per frame; 1 or 2.

- CLK  in  1  system clock, all logic on rising edge.
- R  in  1  reset, synchronous, active-high.
- DATA  in  DATA_BITS  byte to transmit; sampled only on acceptance.
- VALID  in  1  source has a byte on DATA.
- READY  out  1  controller can accept a byte this cycle.
- TXD  out  1  serial line, idle high.
- BUSY  out  1  frame in progress.
- BIT_CE  out  1  one-cycle strobe on the last cycle of every serial bit.

## Operation
- Reset (R=1 at a rising edge): state IDLE, TXD=1, READY=1, BUSY=0, BIT_CE=0, divider and bit counter cleared. Reset wins over every other event, including mid-frame; the line returns to idle high on the next cycle, with no partial stop bit emitted.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: READY=1, TXD=1. If VALID=1 at an edge, DATA is latched into a shift register, parity is computed from the latched value, and the state moves to START. VALID=0 keeps IDLE.
- START: TXD=0 for CLK_DIV cycles.
- DATA: TXD = shift register bit 0. The shift register shifts right on each BIT_CE. The bit counter steps 0..DATA_BITS-1 and saturates. The state leaves DATA on the BIT_CE where counter = DATA_BITS-1.
- PARITY (macro only): TXD = XOR of the latched data bits (even parity), for one bit period.
- STOP: TXD=1 for STOP_BITS bit periods, then IDLE.
- Divider: counts 0..CLK_DIV-1 while BUSY, wraps to 0. BIT_CE=1 when it equals CLK_DIV-1. It is held at 0 in IDLE.
- The bit counter clears on entry to DATA and again on entry to STOP, where it counts stop bits.
- BUSY=1 in every state except IDLE. READY = !BUSY, combinational from state.
- VALID while BUSY is ignored. The source must hold it until the handshake completes.
- Changes on DATA after acceptance have no effect on the frame in flight.

## Timing
- Accept edge t0 (VALID & READY). TXD falls to 0 at t0+1 and READY drops at t0+1.
- Frame length is F = CLK_DIV × (1 + DATA_BITS + P + STOP_BITS) cycles, where P=1 with parity and 0 without. TXD holds each bit for exactly CLK_DIV cycles.
- The last stop-bit cycle is at t0+F, with BIT_CE=1. State is IDLE and READY=1 at t0+F+1.
- The earliest next accept edge is t0+F+1, so the next start bit begins at t0+F+2. That gives at least one idle-high cycle between back-to-back frames.
- Output registers: TXD, BUSY and BIT_CE are registered. READY is derived directly from the state register, with no added latency.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is present, frames carry one even-parity bit, and F includes P=1.
- UART_TX_PARITY_EN undefined: the PARITY state and parity logic are not compiled, DATA goes directly to STOP, and P=0.

## Test plan
- Reset check: hold R=1 for 3 cycles, then release with VALID=0. Required: TXD=1, READY=1, BUSY=0 and BIT_CE=0 every cycle.
- Single frame: CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, no parity, send 0xA5. Required: TXD, sampled every 4 cycles from t0+1, reads 0,1,0,1,0,0,1,0,1,1. READY returns to 1 at t0+41.
- Parity: with UART_TX_PARITY_EN, send 0x07 with CLK_DIV=4. Required: the parity bit is 1 (even parity), the frame lasts 44 cycles, and a second run sending 0x03 gives a parity bit of 0.
- Back-to-back: hold VALID=1 with 0x55 then 0xAA. Required: the second accept occurs at t0+41, with exactly one idle-high cycle between stop and start. DATA is changed mid-frame to 0xFF and the serialised bits still match 0x55.
- Reset mid-frame: assert R for 1 cycle during the 3rd data bit. Required: TXD=1, BUSY=0 and READY=1 on the following cycle. A new 0x81 frame then sends correctly.
- Config corners: DATA_BITS=5, STOP_BITS=2, CLK_DIV=2, send 0x1F. Required: the frame lasts 16 cycles, and BIT_CE pulses 8 times, every 2nd cycle.
